// File: rtl/color_scan_ctrl_pkg.sv
// Shared definitions for the colour-sensor sequencer and the mission controller:
// colour codes, filter-select codes and scan states.
package color_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      COLOR_NONE  = 2'b00,
      COLOR_RED   = 2'b01,
      COLOR_GREEN = 2'b10,
      COLOR_BLUE  = 2'b11
   } color_e;

   // {S2,S3} pin encoding of the TCS230 photodiode filters
   typedef enum logic [1:0] {
      SEL_R     = 2'b00,
      SEL_B     = 2'b01,
      SEL_CLEAR = 2'b10,
      SEL_G     = 2'b11
   } sel_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETTLE   = 2'd1,
      ST_COUNT    = 2'd2,
      ST_CLASSIFY = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      FLT_R = 2'd0,
      FLT_G = 2'd1,
      FLT_B = 2'd2
   } filter_e;

   function automatic sel_e filter_sel(input filter_e f);
      sel_e s;
      case (f)
         FLT_R:   s = SEL_R;
         FLT_G:   s = SEL_G;
         FLT_B:   s = SEL_B;
         default: s = SEL_CLEAR;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/color_scan_ctrl_if.sv
// Sensor-pin and result bundle of one colour-scan sequencer.
interface color_scan_ctrl_if;
   logic       enable;
   logic       wave;
   logic [1:0] select;
   logic       led;
   logic [1:0] color;
   logic       valid;
   logic       busy;

   // master: mission controller / sensor side, slave: the sequencer
   modport master (output enable, output wave,
                   input select, input led, input color, input valid, input busy);
   modport slave  (input enable, input wave,
                   output select, output led, output color, output valid, output busy);
endinterface

// File: rtl/color_scan_ctrl_edge_counter.sv
// Synchronises the sensor square wave, detects rising edges and keeps a
// saturating count of them while enabled.
module edge_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wave_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o
);

   // [0],[1] form the synchroniser, [2] holds the previous synchronised level
   logic [2:0]       sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rise;

   assign rise = sync_q[1] & ~sync_q[2];

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && rise && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[1:0], wave_i};
         cnt_q  <= cnt_d;
      end
   end

   // next-state value, so an edge detected in the last window cycle is included
   assign count_o = cnt_d;

endmodule

// File: rtl/color_scan_ctrl.sv
// Colour-sensor sequencer: steps the filter through R, G, B, counts the sensor
// wave per filter and publishes the dominant colour with a one-cycle strobe.
module color_scan_ctrl
   import color_scan_ctrl_pkg::*;
#(
   parameter int SETTLE_CYC = 50_000,
   parameter int WINDOW_CYC = 500_000,
   parameter int CNT_W      = 16,
   parameter int TMR_W      = 20,
   parameter int MIN_COUNT  = 20
) (
   input logic              clk,
   input logic              rst,
   color_scan_ctrl_if.slave bus
);

   state_e           state_q, state_d;
   filter_e          f_q, f_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] cnt_r_q, cnt_r_d, cnt_g_q, cnt_g_d, cnt_b_q, cnt_b_d;
   color_e           color_q, color_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] tally;

   edge_counter #(.CNT_W(CNT_W)) u_edge (
      .clk_i   (clk),
      .rst_i   (rst),
      .wave_i  (bus.wave),
      .clr_i   (state_q != ST_COUNT),
      .en_i    (state_q == ST_COUNT),
      .count_o (tally)
   );

   // ties favour R, then G
   function automatic color_e classify(input logic [CNT_W-1:0] r, g, b);
      logic [CNT_W-1:0] m;
      color_e           c;
      if (r >= g && r >= b) begin
         m = r;
         c = COLOR_RED;
      end else if (g >= b) begin
         m = g;
         c = COLOR_GREEN;
      end else begin
         m = b;
         c = COLOR_BLUE;
      end
      if (m < CNT_W'(MIN_COUNT))
         c = COLOR_NONE;
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      tmr_d   = tmr_q;
      cnt_r_d = cnt_r_q;
      cnt_g_d = cnt_g_q;
      cnt_b_d = cnt_b_q;
      color_d = color_q;
      valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.enable) begin
               state_d = ST_SETTLE;
               f_d     = FLT_R;
               tmr_d   = '0;
            end
         end
         ST_SETTLE: begin
            if (!bus.enable) begin
               state_d = ST_IDLE;
               tmr_d   = '0;
            end else if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
               state_d = ST_COUNT;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         ST_COUNT: begin
            if (!bus.enable) begin
               state_d = ST_IDLE;
               tmr_d   = '0;
            end else if (tmr_q == TMR_W'(WINDOW_CYC - 1)) begin
               tmr_d = '0;
               case (f_q)
                  FLT_R: begin
                     cnt_r_d = tally;
                     f_d     = FLT_G;
                     state_d = ST_SETTLE;
                  end
                  FLT_G: begin
                     cnt_g_d = tally;
                     f_d     = FLT_B;
                     state_d = ST_SETTLE;
                  end
                  default: begin
                     cnt_b_d = tally;
                     state_d = ST_CLASSIFY;
                  end
               endcase
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         ST_CLASSIFY: begin
            color_d = classify(cnt_r_q, cnt_g_q, cnt_b_q);
            valid_d = 1'b1;
            f_d     = FLT_R;
            tmr_d   = '0;
            state_d = bus.enable ? ST_SETTLE : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         f_q     <= FLT_R;
         tmr_q   <= '0;
         cnt_r_q <= '0;
         cnt_g_q <= '0;
         cnt_b_q <= '0;
         color_q <= COLOR_NONE;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         tmr_q   <= tmr_d;
         cnt_r_q <= cnt_r_d;
         cnt_g_q <= cnt_g_d;
         cnt_b_q <= cnt_b_d;
         color_q <= color_d;
         valid_q <= valid_d;
      end
   end

   assign bus.select = (state_q == ST_IDLE) ? SEL_CLEAR : filter_sel(f_q);
   assign bus.led    = (state_q != ST_IDLE);
   assign bus.busy   = (state_q != ST_IDLE);
   assign bus.color  = color_q;
   assign bus.valid  = valid_q;

endmodule

// File: tb/tb_color_scan_ctrl.sv
// Bench for color_scan_ctrl: directed and random scans checked against a
// count-per-filter colour model; a wider-window instance covers saturation.
module tb_color_scan_ctrl;

   localparam int S    = 4;
   localparam int W1   = 20;
   localparam int W2   = 40;
   localparam int MINC = 3;
   localparam int CMAX = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   color_scan_ctrl_if mif ();
   color_scan_ctrl_if sif ();

   color_scan_ctrl #(.SETTLE_CYC(S), .WINDOW_CYC(W1), .CNT_W(4), .TMR_W(8), .MIN_COUNT(MINC))
      u_dut (.clk(clk), .rst(rst), .bus(mif));

   color_scan_ctrl #(.SETTLE_CYC(S), .WINDOW_CYC(W2), .CNT_W(4), .TMR_W(8), .MIN_COUNT(MINC))
      u_sat (.clk(clk), .rst(rst), .bus(sif));

   int         tests = 0;
   int         fails = 0;
   bit         pend  = 1'b0;
   logic [1:0] exp_col;
   logic [1:0] held [2];

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // dominant colour from per-filter edge totals, counters clipped at CMAX
   function automatic logic [1:0] ref_color(input int nr, input int ng, input int nb);
      int c [3];
      int m;
      c[0] = (nr > CMAX) ? CMAX : nr;
      c[1] = (ng > CMAX) ? CMAX : ng;
      c[2] = (nb > CMAX) ? CMAX : nb;
      m = c[0];
      if (c[1] > m) m = c[1];
      if (c[2] > m) m = c[2];
      if (m < MINC) return 2'd0;
      for (int i = 0; i < 3; i++)
         if (c[i] == m) return 2'(i + 1);
      return 2'd0;
   endfunction

   function automatic logic [1:0] sel_of(input int k, input int t);
      int f;
      f = k / t;
      if (f > 2) f = 2;
      return (f == 0) ? 2'b00 : (f == 1) ? 2'b11 : 2'b01;
   endfunction

   // n one-cycle pulses per filter, placed inside that filter's count window
   function automatic logic wave_at(input int k, input int t, input int nr, input int ng, input int nb);
      int n [3];
      int st;
      n[0] = nr; n[1] = ng; n[2] = nb;
      for (int f = 0; f < 3; f++) begin
         st = f * t + S - 1;
         if (k >= st && k < st + 2 * n[f] && ((k - st) % 2 == 0)) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic rd(input bit u, output logic [1:0] v, output logic [1:0] sl,
                     output logic [1:0] cl, output logic [1:0] bz, output logic [1:0] ld);
      v  = {1'b0, u ? sif.valid : mif.valid};
      sl = u ? sif.select : mif.select;
      cl = u ? sif.color : mif.color;
      bz = {1'b0, u ? sif.busy : mif.busy};
      ld = {1'b0, u ? sif.led : mif.led};
   endtask

   // one scan starting in its first SETTLE cycle; cut >= 0 aborts (enable or rst) at step cut
   task automatic scan(input bit u, input int nr, input int ng, input int nb,
                       input bit stop, input int cut, input bit cut_rst);
      int t;
      logic [1:0] v, sl, cl, bz, ld;
      t = S + (u ? W2 : W1);
      for (int k = 0; k <= 3 * t; k++) begin
         @(negedge clk);
         rd(u, v, sl, cl, bz, ld);
         if (k == 0 && pend) begin
            chk("valid_strobe", v, 2'd1);
            chk("color_new", cl, exp_col);
            held[u] = exp_col;
            pend = 1'b0;
         end else begin
            chk("valid_quiet", v, 2'd0);
            chk("color_held", cl, held[u]);
         end
         chk("select", sl, sel_of(k, t));
         chk("busy_scan", bz, 2'd1);
         if (u) sif.wave = wave_at(k, t, nr, ng, nb);
         else   mif.wave = wave_at(k, t, nr, ng, nb);
         if (k == cut) begin
            if (cut_rst) rst = 1'b1;
            else if (u) sif.enable = 1'b0;
            else mif.enable = 1'b0;
            return;
         end
         if (k == 3 * t && stop) begin
            if (u) sif.enable = 1'b0;
            else mif.enable = 1'b0;
         end
      end
      exp_col = ref_color(nr, ng, nb);
      pend = 1'b1;
   endtask

   // result cycle after a scan whose enable dropped during CLASSIFY
   task automatic land(input bit u);
      logic [1:0] v, sl, cl, bz, ld;
      @(negedge clk);
      rd(u, v, sl, cl, bz, ld);
      chk("valid_strobe", v, 2'd1);
      chk("color_new", cl, exp_col);
      chk("busy_after", bz, 2'd0);
      chk("led_after", ld, 2'd0);
      chk("select_after", sl, 2'b10);
      held[u] = exp_col;
      pend = 1'b0;
      @(negedge clk);
      rd(u, v, sl, cl, bz, ld);
      chk("valid_one_cycle", v, 2'd0);
      chk("color_kept", cl, held[u]);
   endtask

   task automatic chk_idle(input string tag, input bit u);
      logic [1:0] v, sl, cl, bz, ld;
      rd(u, v, sl, cl, bz, ld);
      chk({tag, "_valid"}, v, 2'd0);
      chk({tag, "_busy"}, bz, 2'd0);
      chk({tag, "_led"}, ld, 2'd0);
      chk({tag, "_select"}, sl, 2'b10);
      chk({tag, "_color"}, cl, held[u]);
   endtask

   initial begin
      held[0] = 2'd0;
      held[1] = 2'd0;
      rst = 1'b1;
      mif.enable = 1'b0; mif.wave = 1'b0;
      sif.enable = 1'b0; sif.wave = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle("reset", 1'b0);
      chk_idle("reset_sat", 1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk_idle("idle_no_enable", 1'b0);

      // red dominance, then below threshold, then exact threshold on G
      mif.enable = 1'b1; scan(1'b0, 5, 0, 0, 1'b1, -1, 1'b0); land(1'b0);
      mif.enable = 1'b1; scan(1'b0, 2, 2, 2, 1'b1, -1, 1'b0); land(1'b0);
      mif.enable = 1'b1; scan(1'b0, 0, 3, 2, 1'b1, -1, 1'b0); land(1'b0);

      // abort during the G count window
      mif.enable = 1'b1; scan(1'b0, 4, 4, 0, 1'b0, 35, 1'b0);
      mif.wave = 1'b0;
      @(negedge clk);
      chk_idle("abort", 1'b0);
      repeat (4) begin
         @(negedge clk);
         chk_idle("abort_hold", 1'b0);
      end

      // continuous mode with random counts
      mif.enable = 1'b1;
      for (int i = 0; i < 4; i++)
         scan(1'b0, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
              int'($urandom_range(0, 9)), i == 3, -1, 1'b0);
      land(1'b0);

      // reset during B SETTLE, enable still high
      mif.enable = 1'b1; scan(1'b0, 6, 0, 0, 1'b0, 50, 1'b1);
      @(negedge clk);
      held[0] = 2'd0;
      chk_idle("rst_mid", 1'b0);
      rst = 1'b0; mif.enable = 1'b0; mif.wave = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_idle("rst_wait", 1'b0);
      end
      mif.enable = 1'b1; scan(1'b0, 1, 7, 0, 1'b1, -1, 1'b0); land(1'b0);

      // saturation: R=16, G=19 must clip to a 15/15 tie, then B alone
      sif.enable = 1'b1;
      scan(1'b1, 16, 19, 0, 1'b0, -1, 1'b0);
      scan(1'b1, 0, 0, 8, 1'b1, -1, 1'b0);
      land(1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/color_scan_ctrl.md
# color_scan_ctrl

Sequencer for one TCS230-style colour sensor. It drives the filter-select lines and the illumination LED, and gates a pulse count of the sensor's square wave for each filter. It then classifies the dominant colour and publishes it with a one-cycle valid strobe. One instance serves the object sensor and one serves the station sensor. Both sit between the sensor pins and the mission controller, which reads the 2-bit colour code.

## Interface
Parameters:
- SETTLE_CYC, 50_000 — cycles to wait after a filter change before counting (1 ms at 50 MHz).
- WINDOW_CYC, 500_000 — cycles of the counting window per filter (10 ms).
- CNT_W, 16 — width of each per-filter edge counter.
- TMR_W, 20 — width of the phase timer; must satisfy 2^TMR_W > max(SETTLE_CYC, WINDOW_CYC).
- MIN_COUNT, 20 — minimum winning count for a valid colour; below it the result is NONE.

Ports:
- clk  in  1  system clock, 50 MHz; the only clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; high = scan continuously, low = idle.
- wave  in  1  asynchronous square wave from the sensor.
- select  out  2  filter select {S2,S3}: R = 00, G = 11, B = 01, clear = 10.
- led  out  1  sensor illumination, high while not IDLE.
- color  out  2  last classified colour: 00 NONE, 01 RED, 10 GREEN, 11 BLUE.
- valid  out  1  one-cycle strobe when color is updated.
- busy  out  1  high while not IDLE.

## Operation
- `wave` passes through a 2-flop synchronizer and then a rising-edge detector.
- A counter counts detected edges only in the COUNT state.
- The counter saturates at 2^CNT_W−1 and never wraps.
- States: IDLE, SETTLE, COUNT, CLASSIFY. A filter index f cycles R → G → B.
- IDLE:
  - select = clear (10), led = 0, busy = 0.
  - On enable = 1, go to SETTLE with f = R and timer = 0.
- SETTLE:
  - select = code(f).
  - Timer increments each cycle; after SETTLE_CYC cycles, clear the edge counter and go to COUNT.
- COUNT:
  - Timer runs for WINDOW_CYC cycles while edges are counted.
  - At the end, latch the counter into cnt[f].
  - If f = B, go to CLASSIFY; otherwise advance f and return to SETTLE.
- CLASSIFY (one cycle):
  - m = max(cnt_R, cnt_G, cnt_B).
  - Ties resolve R over G over B.
  - If m < MIN_COUNT, result = NONE; otherwise result = the winning colour.
  - Register the result into color and pulse valid.
  - If enable = 1, return to SETTLE with f = R; otherwise go to IDLE.
- If enable drops in SETTLE or COUNT, go to IDLE on the next edge:
  - The partial scan is discarded.
  - color is held and valid is not pulsed.
- color holds its value between scans and across IDLE; only rst or CLASSIFY changes it.
- Comparisons are unsigned, CNT_W bits wide.

## Timing
- Reset values: select = 10, led = 0, color = 00, valid = 0, busy = 0, state = IDLE, all counters and timers = 0.
- If rst is asserted mid-scan, the next cycle is the reset state with no valid pulse.
- Scan latency: from the first cycle in SETTLE to valid high is exactly 3·(SETTLE_CYC + WINDOW_CYC) + 1 cycles.
- enable sampled high in IDLE puts the block in SETTLE in the following cycle.
- In continuous mode, consecutive valid strobes are 3·(SETTLE_CYC + WINDOW_CYC) + 1 cycles apart.
- valid is high for exactly 1 cycle, in the same cycle that color first shows the new value.
- Edge counting window:
  - A wave edge reaches the counter 3 cycles after the pin (2 sync + 1 detect).
  - Edges in flight at a state boundary count only if their detect pulse falls inside COUNT.
- select changes on the clock edge entering SETTLE; it is stable throughout SETTLE and COUNT.
- Simultaneous enable fall and CLASSIFY: the result is still published (valid pulses), then the block goes to IDLE.

## Structure
- Shared package (also used by the mission controller):
  - Colour code constants COLOR_NONE / RED / GREEN / BLUE.
  - Filter-select constants SEL_R / G / B / CLEAR.
  - State encoding.
- Sub-module `edge_counter`: synchronizer, rising-edge detect, saturating count with clear and enable inputs.
- The FSM, timer and classifier live in color_scan_ctrl.

## Test plan
Bench parameters: SETTLE_CYC = 4, WINDOW_CYC = 20, CNT_W = 4, MIN_COUNT = 3.
- Red dominance: wave toggles every 2 cycles while select = 00, static otherwise -> color = 01, valid for 1 cycle exactly 73 cycles after entering SETTLE.
- Below threshold: each filter gets 2 edges -> color = 00 (NONE), valid pulses.
- Tie and saturation: R and G both ≥ 15 edges -> both counts saturate at 15 with no wrap, color = 01 (R wins the tie). Then B alone receives 8 edges (R = G = 0) -> color = 11.
- Abort: enable drops during the G COUNT phase -> IDLE the next cycle, led = 0, select = 10, previous color held, no valid pulse.
- Reset mid-scan: rst held for 1 cycle during B SETTLE -> all outputs at reset values the next cycle. A scan restarts only after enable is seen high in IDLE.
- Continuous mode: enable held high for 3 scans -> valid strobes exactly 73 cycles apart, and select follows R, G, B, R… without passing through clear.
